sysctl: RTL and testbench

- System-control CSR peripheral that consumes the 32-bit capabilities word and exposes it to software as a read-only register.
- Also provides GPIO input sampling with change interrupts, GPIO outputs, up to two 32-bit timers with compare interrupts, and a software-triggered hard-reset pulse.
- Sits on the CSR bus alongside the other system peripherals.

---
 rtl/sysctl.sv | 143 ++++++++++++++
 tb/tb_sysctl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sysctl.sv
// System-control CSR block: GPIO sampling/outputs, compare timers, capability word, hard-reset pulse.
// Timer1 is built only when SYSCTL_TIMER1_EN is defined.
module sysctl #(
  parameter logic [3:0] csr_addr = 4'h1,
  parameter int         ninputs  = 7,
  parameter int         noutputs = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [13:0]         csr_a,
  input  logic                csr_we,
  input  logic [31:0]         csr_di,
  output logic [31:0]         csr_do,
  input  logic [31:0]         capabilities,
  input  logic [ninputs-1:0]  gpio_inputs,
  output logic [noutputs-1:0] gpio_outputs,
  output logic                gpio_irq,
  output logic                timer0_irq,
  output logic                timer1_irq,
  output logic                hard_reset
);

`ifdef SYSCTL_TIMER1_EN
  localparam int NTIMERS = 2;
`else
  localparam int NTIMERS = 1;
`endif

  logic             sel;
  logic             wr;
  logic [4:0]       reg_a;
  logic             unused_addr;
  logic [31:0]      rdata;

  logic [ninputs-1:0] gpio_in_p0, gpio_in_p1, gpio_in_p2;
  logic [ninputs-1:0] gpio_irq_en;

  logic [NTIMERS-1:0] t_en, t_ar, t_irq;
  logic [31:0]        t_cmp [NTIMERS];
  logic [31:0]        t_cnt [NTIMERS];

  assign sel         = (csr_a[13:10] == csr_addr);
  assign wr          = sel & csr_we;
  assign reg_a       = csr_a[4:0];
  assign unused_addr = ^csr_a[9:5];

  // GPIO: two synchroniser stages (_p0, _p1), then the previous-value stage (_p2)
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gpio_in_p0 <= '0;
      gpio_in_p1 <= '0;
      gpio_in_p2 <= '0;
      gpio_irq   <= 1'b0;
    end else begin
      gpio_in_p0 <= gpio_inputs;
      gpio_in_p1 <= gpio_in_p0;
      gpio_in_p2 <= gpio_in_p1;
      gpio_irq   <= |((gpio_in_p1 ^ gpio_in_p2) & gpio_irq_en);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gpio_outputs <= '0;
      gpio_irq_en  <= '0;
      hard_reset   <= 1'b0;
    end else begin
      hard_reset <= wr && (reg_a == 5'h1F);
      if (wr && (reg_a == 5'h01)) gpio_outputs <= csr_di[noutputs-1:0];
      if (wr && (reg_a == 5'h02)) gpio_irq_en  <= csr_di[ninputs-1:0];
    end
  end

  // Timer i lives at 4*(i+1) + {0:ctrl, 1:compare, 2:counter}; a CSR write
  // is applied after the match update so it wins for the field it touches.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NTIMERS; i++) begin
      if (sys_rst) begin
        t_en[i]  <= 1'b0;
        t_ar[i]  <= 1'b0;
        t_irq[i] <= 1'b0;
        t_cnt[i] <= '0;
        t_cmp[i] <= '1;
      end else begin
        t_irq[i] <= t_en[i] && (t_cnt[i] == t_cmp[i]);
        if (t_en[i]) begin
          if (t_cnt[i] == t_cmp[i]) begin
            if (t_ar[i]) t_cnt[i] <= '0;
            else         t_en[i]  <= 1'b0;
          end else begin
            t_cnt[i] <= t_cnt[i] + 32'd1;
          end
        end
        if (wr && (int'(reg_a[4:2]) == i + 1)) begin
          case (reg_a[1:0])
            2'd0: begin
              t_en[i] <= csr_di[0];
              t_ar[i] <= csr_di[1];
            end
            2'd1:    t_cmp[i] <= csr_di;
            2'd2:    t_cnt[i] <= csr_di;
            default: ;
          endcase
        end
      end
    end
  end

  assign timer0_irq = t_irq[0];
`ifdef SYSCTL_TIMER1_EN
  assign timer1_irq = t_irq[1];
`else
  assign timer1_irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_a)
      5'h00:   rdata = 32'(gpio_in_p1);
      5'h01:   rdata = 32'(gpio_outputs);
      5'h02:   rdata = 32'(gpio_irq_en);
      5'h1E:   rdata = capabilities;
      default: ;
    endcase
    for (int i = 0; i < NTIMERS; i++) begin
      if (int'(reg_a[4:2]) == i + 1) begin
        case (reg_a[1:0])
          2'd0:    rdata = {30'b0, t_ar[i], t_en[i]};
          2'd1:    rdata = t_cmp[i];
          2'd2:    rdata = t_cnt[i];
          default: ;
        endcase
      end
    end
  end

  // Read stage: registered, zero whenever the page is not selected
  always_ff @(posedge sys_clk) begin
    if (sys_rst) csr_do <= '0;
    else         csr_do <= sel ? rdata : 32'd0;
  end

endmodule

// File: tb/tb_sysctl.sv
// Directed bench for sysctl: event-schedule model checked against the outputs every cycle.
module tb_sysctl;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic [31:0] capabilities;
  logic [6:0]  gpio_inputs;
  logic [1:0]  gpio_outputs;
  logic        gpio_irq, timer0_irq, timer1_irq, hard_reset;

  sysctl dut (
    .sys_clk(clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
    .csr_di(csr_di), .csr_do(csr_do), .capabilities(capabilities),
    .gpio_inputs(gpio_inputs), .gpio_outputs(gpio_outputs), .gpio_irq(gpio_irq),
    .timer0_irq(timer0_irq), .timer1_irq(timer1_irq), .hard_reset(hard_reset)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  int last_wr = 0;

  // Expected events, keyed by the cycle (rising edge index) at which they are visible
  bit          t0_irq_at  [int];
  bit          gpio_irq_at[int];
  bit          hr_at      [int];
  bit          skip_do    [int];
  logic [31:0] exp_do     [int];
  logic [1:0]  gpo_change [int];
  logic [1:0]  mdl_gpo = 2'b00;
  logic [6:0]  mdl_irq_en = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (chk_en) begin
        if (gpo_change.exists(cyc)) mdl_gpo = gpo_change[cyc];
        chk("gpio_outputs", 32'(gpio_outputs), 32'(mdl_gpo));
        chk("timer0_irq", 32'(timer0_irq), 32'(t0_irq_at.exists(cyc)));
        chk("timer1_irq", 32'(timer1_irq), 32'd0);
        chk("gpio_irq", 32'(gpio_irq), 32'(gpio_irq_at.exists(cyc)));
        chk("hard_reset", 32'(hard_reset), 32'(hr_at.exists(cyc)));
        if (!skip_do.exists(cyc))
          chk("csr_do", csr_do, exp_do.exists(cyc) ? exp_do[cyc] : 32'd0);
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    csr_a = 14'h0; csr_we = 1'b0; csr_di = '0;
  endtask

  // Returns at the negedge from which the next task's transfer samples on edge m
  task automatic idle_until(input int m);
    while (cyc < m - 2) idle();
  endtask

  task automatic csr_write(input logic [4:0] a, input logic [31:0] d);
    int s;
    @(negedge clk);
    csr_a = {4'h1, 5'b0, a}; csr_we = 1'b1; csr_di = d;
    s = cyc + 1;
    skip_do[s] = 1'b1;
    case (a)
      5'h01:   gpo_change[s] = d[1:0];
      5'h02:   mdl_irq_en = d[6:0];
      5'h1F:   hr_at[s] = 1'b1;
      default: ;
    endcase
    last_wr = s;
  endtask

  task automatic csr_read(input logic [3:0] page, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    csr_a = {page, 5'b0, a}; csr_we = 1'b0; csr_di = '0;
    exp_do[cyc + 1] = exp;
  endtask

  task automatic set_gpio(input logic [6:0] v);
    @(negedge clk);
    csr_a = 14'h0; csr_we = 1'b0; csr_di = '0;
    if (((v ^ gpio_inputs) & mdl_irq_en) != '0) gpio_irq_at[cyc + 3] = 1'b1;
    gpio_inputs = v;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    csr_a = 14'h0; csr_we = 1'b0; csr_di = '0;
    sys_rst = 1'b1;
    gpo_change[cyc + 1] = 2'b00;
    mdl_irq_en = '0;
    @(negedge clk);
    sys_rst = 1'b0;
  endtask

  initial begin
    int s;
    sys_rst = 1'b1; csr_a = '0; csr_we = 1'b0; csr_di = '0;
    gpio_inputs = '0; capabilities = 32'h0000_0010;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    chk_en  = 1'b1;

    // Reset values, capabilities, page select, unmapped/RO writes
    csr_read(4'h1, 5'h00, 32'h0);
    csr_read(4'h1, 5'h01, 32'h0);
    csr_read(4'h1, 5'h02, 32'h0);
    csr_read(4'h1, 5'h04, 32'h0);
    csr_read(4'h1, 5'h05, 32'hFFFF_FFFF);
    csr_read(4'h1, 5'h06, 32'h0);
    csr_read(4'h1, 5'h1E, 32'h0000_0010);
    csr_read(4'h2, 5'h1E, 32'h0);
    csr_read(4'h1, 5'h03, 32'h0);
    csr_write(5'h1E, 32'h5);
    csr_write(5'h03, 32'hFFFF_FFFF);
    csr_read(4'h1, 5'h1E, 32'h0000_0010);
    csr_read(4'h1, 5'h03, 32'h0);

    // One-shot: counts 0..9, pulses once, then EN=0 with counter held at 9
    csr_write(5'h05, 32'd9);
    csr_write(5'h04, 32'h1);
    s = last_wr;
    t0_irq_at[s + 10] = 1'b1;
    repeat (14) idle();
    csr_read(4'h1, 5'h04, 32'h0);
    csr_read(4'h1, 5'h06, 32'd9);
    csr_read(4'h1, 5'h05, 32'd9);

    // Autorestart with compare 3: period 4, counter 0,1,2,3,0
    csr_write(5'h06, 32'd0);
    csr_write(5'h05, 32'd3);
    csr_write(5'h04, 32'h3);
    s = last_wr;
    for (int k = 0; k < 4; k++) t0_irq_at[s + 4 + 4 * k] = 1'b1;
    for (int j = 0; j < 5; j++) csr_read(4'h1, 5'h06, 32'(j % 4));
    csr_read(4'h1, 5'h04, 32'h3);
    idle_until(s + 16);
    csr_write(5'h04, 32'h0);
    repeat (3) idle();
    csr_read(4'h1, 5'h06, 32'd0);
    csr_read(4'h1, 5'h04, 32'h0);

    // GPIO change interrupts and synchronised read-back
    csr_write(5'h02, 32'h1);
    repeat (2) idle();
    set_gpio(7'b0000001);
    repeat (6) idle();
    set_gpio(7'b0000011);
    repeat (6) idle();
    csr_read(4'h1, 5'h00, 32'h3);
    set_gpio(7'b0000010);
    repeat (6) idle();
    csr_read(4'h1, 5'h00, 32'h2);
    csr_read(4'h1, 5'h02, 32'h1);

    // GPIO outputs and hard reset pulses (single, then back-to-back)
    csr_write(5'h01, 32'h3);
    csr_read(4'h1, 5'h01, 32'h3);
    csr_write(5'h1F, 32'hDEAD_BEEF);
    repeat (2) idle();
    csr_write(5'h1F, 32'h1);
    csr_write(5'h1F, 32'h2);
    repeat (3) idle();

    // Timer1 region
    csr_write(5'h08, 32'h1);
`ifdef SYSCTL_TIMER1_EN
    csr_read(4'h1, 5'h08, 32'h1);
`else
    csr_read(4'h1, 5'h08, 32'h0);
`endif
    repeat (1000) idle();
    csr_write(5'h08, 32'h0);
    idle();

    // Reset landing on a match edge: no pulse, everything back to reset values
    csr_write(5'h06, 32'd0);
    csr_write(5'h05, 32'd3);
    csr_write(5'h04, 32'h3);
    s = last_wr;
    t0_irq_at[s + 4] = 1'b1;
    idle_until(s + 8);
    mid_reset();
    csr_read(4'h1, 5'h06, 32'h0);
    csr_read(4'h1, 5'h05, 32'hFFFF_FFFF);
    csr_read(4'h1, 5'h04, 32'h0);
    csr_read(4'h1, 5'h01, 32'h0);
    csr_read(4'h1, 5'h02, 32'h0);
    repeat (8) idle();

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
